// File: rtl/fp_unit_pkg.sv
// Shared types and constants for the FP execute unit.
package fp_wire;

  typedef struct packed {
    logic       fmadd;
    logic       fadd;
    logic       fsub;
    logic       fmul;
    logic       fdiv;
    logic       fsqrt;
    logic       fcmp;
    logic       fcvt_i2f;
    logic       fcvt_f2i;
    logic [1:0] fcvt_op;
  } fp_operation_type;

  localparam fp_operation_type init_fp_operation = '0;

  typedef struct packed {
    logic [31:0]      data1;
    logic [31:0]      data2;
    logic [31:0]      data3;
    logic [1:0]       fmt;
    logic [2:0]       rm;
    fp_operation_type op;
    logic             enable;
  } fp_exe_in_type;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  flags;
    logic        ready;
  } fp_exe_out_type;

  typedef struct packed {
    fp_exe_in_type fp_exe_i;
  } fp_unit_in_type;

  typedef struct packed {
    fp_exe_out_type fp_exe_o;
  } fp_unit_out_type;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  // Increment decision for a truncated magnitude; rm 5-7 fall back to RNE.
  function automatic logic rnd_up(input logic sign, input logic lsb, input logic g,
                                  input logic s, input logic [2:0] rm);
    case (rm)
      RM_RTZ:  rnd_up = 1'b0;
      RM_RDN:  rnd_up = sign & (g | s);
      RM_RUP:  rnd_up = ~sign & (g | s);
      RM_RMM:  rnd_up = g;
      default: rnd_up = g & (s | lsb);
    endcase
  endfunction

  // Leading-zero count of a 24-bit mantissa (24 when all zero).
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    lzc24 = 5'd24;
    for (int i = 0; i < 24; i++)
      if (v[i]) lzc24 = 5'(23 - i);
  endfunction

endpackage

// File: rtl/fp_unit_rnd.sv
// Combinational binary32 rounding: denormalise tiny results, round, detect OF/UF/NX.
import fp_wire::*;

module fp_rnd (
  input  logic              sign,
  input  logic signed [9:0] exp,
  input  logic [23:0]       mant,
  input  logic              guard,
  input  logic              sticky,
  input  logic [2:0]        rm,
  output logic [31:0]       result,
  output logic              of,
  output logic              uf,
  output logic              nx
);

  logic              carry_norm, tiny, g_w, s_w, up, inexact, ovf_inf;
  logic signed [9:0] sh_full, e_w, e_f;
  logic [4:0]        sh;
  logic [49:0]       full;
  logic [23:0]       m_w;
  logic [24:0]       rounded;
  logic [22:0]       frac;

  // Denormalise, round, then pack or saturate on overflow.
  always_comb begin
    // Tininess is judged after rounding with an unbounded exponent.
    carry_norm = (&mant) & rnd_up(sign, mant[0], guard, sticky, rm);
    tiny       = (exp < 10'sd0) | ((exp == 10'sd0) & ~carry_norm);
    sh_full    = 10'sd1 - exp;
    sh         = (sh_full > 10'sd25) ? 5'd25 : sh_full[4:0];
    full       = {mant, guard, 25'b0} >> sh;
    if (exp <= 10'sd0) begin
      m_w = full[49:26];
      g_w = full[25];
      s_w = sticky | (|full[24:0]);
      e_w = 10'sd0;
    end else begin
      m_w = mant;
      g_w = guard;
      s_w = sticky;
      e_w = exp;
    end
    up      = rnd_up(sign, m_w[0], g_w, s_w, rm);
    rounded = {1'b0, m_w} + {24'b0, up};
    if (e_w == 10'sd0) begin
      e_f  = $signed({9'b0, rounded[23]});
      frac = rounded[22:0];
    end else begin
      e_f  = e_w + $signed({9'b0, rounded[24]});
      frac = rounded[24] ? 23'b0 : rounded[22:0];
    end
    inexact = g_w | s_w;
    ovf_inf = (rm == RM_RTZ) ? 1'b0 :
              (rm == RM_RDN) ? sign :
              (rm == RM_RUP) ? ~sign : 1'b1;
    if (e_f >= 10'sd255) begin
      of     = 1'b1;
      uf     = 1'b0;
      nx     = 1'b1;
      result = ovf_inf ? {sign, 8'hFF, 23'b0} : {sign, 31'h7F7FFFFF};
    end else begin
      of     = 1'b0;
      uf     = tiny & inexact;
      nx     = inexact;
      result = {sign, e_f[7:0], frac};
    end
  end

endmodule

// File: rtl/fp_unit.sv
// Iterative binary32 divide / square-root unit (radix-2 restoring, shared datapath).
import fp_wire::*;

module fp_unit (
  input  logic            clock,
  input  logic            reset,
  input  fp_unit_in_type  fp_unit_i,
  output fp_unit_out_type fp_unit_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
  // cnt 0 normalises, cnt 1..27 produce 26 bits plus guard.
  localparam logic [4:0] LAST_CNT = 5'd27;

  fp_exe_in_type in;
  assign in = fp_unit_i.fp_exe_i;

  logic [1:0]        state_q;
  logic [4:0]        cnt_q;
  logic              sqrt_q, sign_q;
  logic [2:0]        rm_q;
  logic [31:0]       a_q, b_q, result_q;
  logic [4:0]        flags_q;
  logic [29:0]       rem_q;
  logic [26:0]       q_q;
  logic [53:0]       rad_q;
  logic [23:0]       dvs_q;
  logic signed [9:0] exp_q;

  // Operand classification on the request.
  logic [31:0] d1, d2;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, s_x;
  assign d1     = in.data1;
  assign d2     = in.data2;
  assign a_zero = (d1[30:0] == 31'h0);
  assign b_zero = (d2[30:0] == 31'h0);
  assign a_inf  = (&d1[30:23]) & ~(|d1[22:0]);
  assign b_inf  = (&d2[30:23]) & ~(|d2[22:0]);
  assign a_nan  = (&d1[30:23]) & (|d1[22:0]);
  assign b_nan  = (&d2[30:23]) & (|d2[22:0]);
  assign a_snan = a_nan & ~d1[22];
  assign b_snan = b_nan & ~d2[22];
  assign s_x    = d1[31] ^ d2[31];

  logic        spc;
  logic [31:0] spc_res;
  logic [4:0]  spc_flg;

  // Special-operand results that bypass the iteration.
  always_comb begin
    spc     = 1'b0;
    spc_res = 32'h0;
    spc_flg = 5'h0;
    if (in.op.fdiv) begin
      if (a_nan | b_nan) begin
        spc = 1'b1; spc_res = QNAN; spc_flg[FLAG_NV] = a_snan | b_snan;
      end else if ((a_zero & b_zero) | (a_inf & b_inf)) begin
        spc = 1'b1; spc_res = QNAN; spc_flg[FLAG_NV] = 1'b1;
      end else if (b_zero) begin
        spc = 1'b1; spc_res = {s_x, 8'hFF, 23'h0}; spc_flg[FLAG_DZ] = 1'b1;
      end else if (a_inf) begin
        spc = 1'b1; spc_res = {s_x, 8'hFF, 23'h0};
      end else if (b_inf | a_zero) begin
        spc = 1'b1; spc_res = {s_x, 31'h0};
      end
    end else if (in.op.fsqrt) begin
      if (a_nan) begin
        spc = 1'b1; spc_res = QNAN; spc_flg[FLAG_NV] = a_snan;
      end else if (a_zero) begin
        spc = 1'b1; spc_res = d1;
      end else if (d1[31]) begin
        spc = 1'b1; spc_res = QNAN; spc_flg[FLAG_NV] = 1'b1;
      end else if (a_inf) begin
        spc = 1'b1; spc_res = 32'h7F800000;
      end
    end
  end

  // Normalised mantissas / unbiased-domain exponents of the latched operands.
  logic [4:0]        lz_a, lz_b;
  logic [23:0]       ma_n, mb_n;
  logic signed [9:0] ea_e, eb_e, e_unb;
  logic [25:0]       rad_n;
  assign lz_a  = lzc24({1'b0, a_q[22:0]});
  assign lz_b  = lzc24({1'b0, b_q[22:0]});
  assign ma_n  = (a_q[30:23] == 8'h0) ? ({1'b0, a_q[22:0]} << lz_a) : {1'b1, a_q[22:0]};
  assign mb_n  = (b_q[30:23] == 8'h0) ? ({1'b0, b_q[22:0]} << lz_b) : {1'b1, b_q[22:0]};
  assign ea_e  = (a_q[30:23] == 8'h0) ? 10'sd1 - $signed({5'b0, lz_a}) : $signed({2'b0, a_q[30:23]});
  assign eb_e  = (b_q[30:23] == 8'h0) ? 10'sd1 - $signed({5'b0, lz_b}) : $signed({2'b0, b_q[30:23]});
  assign e_unb = ea_e - 10'sd127;
  // Odd exponents fold one factor of two into the radicand.
  assign rad_n = e_unb[0] ? {ma_n, 2'b00} : {1'b0, ma_n, 1'b0};

  // One restoring step for each operation.
  logic        div_ge, sq_ge;
  logic [29:0] div_rem, sq_r2, sq_trial, sq_rem;
  assign div_ge   = rem_q >= {6'b0, dvs_q};
  assign div_rem  = div_ge ? rem_q - {6'b0, dvs_q} : rem_q;
  assign sq_r2    = {rem_q[27:0], rad_q[53:52]};
  assign sq_trial = {1'b0, q_q, 2'b01};
  assign sq_ge    = sq_r2 >= sq_trial;
  assign sq_rem   = sq_ge ? sq_r2 - sq_trial : sq_r2;

  // Quotient below one borrows a bit from the exponent.
  logic [23:0]       r_mant;
  logic              r_g, r_s;
  logic signed [9:0] r_exp;
  assign r_mant = q_q[26] ? q_q[26:3] : q_q[25:2];
  assign r_g    = q_q[26] ? q_q[2] : q_q[1];
  assign r_s    = (q_q[26] ? |q_q[1:0] : q_q[0]) | (|rem_q);
  assign r_exp  = q_q[26] ? exp_q : exp_q - 10'sd1;

  logic [31:0] rnd_res;
  logic        rnd_of, rnd_uf, rnd_nx;

  fp_rnd u_rnd (
    .sign   (sign_q),
    .exp    (r_exp),
    .mant   (r_mant),
    .guard  (r_g),
    .sticky (r_s),
    .rm     (rm_q),
    .result (rnd_res),
    .of     (rnd_of),
    .uf     (rnd_uf),
    .nx     (rnd_nx)
  );

  // Control FSM and iteration registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 5'd0;
      sqrt_q   <= 1'b0;
      sign_q   <= 1'b0;
      rm_q     <= 3'd0;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      result_q <= 32'h0;
      flags_q  <= 5'h0;
      rem_q    <= 30'h0;
      q_q      <= 27'h0;
      rad_q    <= 54'h0;
      dvs_q    <= 24'h0;
      exp_q    <= 10'sd0;
    end else begin
      case (state_q)
        ST_IDLE: if (in.enable) begin
          if (!(in.op.fdiv | in.op.fsqrt)) begin
            result_q <= 32'h0;
            flags_q  <= 5'h0;
            state_q  <= ST_DONE;
          end else if (spc) begin
            result_q <= spc_res;
            flags_q  <= spc_flg;
            state_q  <= ST_DONE;
          end else begin
            a_q     <= d1;
            b_q     <= d2;
            rm_q    <= in.rm;
            sqrt_q  <= ~in.op.fdiv;
            sign_q  <= in.op.fdiv & s_x;
            cnt_q   <= 5'd0;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd0) begin
            q_q <= 27'h0;
            if (sqrt_q) begin
              rem_q <= 30'h0;
              rad_q <= {rad_n, 28'b0};
              exp_q <= $signed({e_unb[9], e_unb[9:1]}) + 10'sd127;
            end else begin
              rem_q <= {6'b0, ma_n};
              dvs_q <= mb_n;
              exp_q <= ea_e - eb_e + 10'sd127;
            end
          end else if (sqrt_q) begin
            rem_q <= sq_rem;
            q_q   <= {q_q[25:0], sq_ge};
            rad_q <= {rad_q[51:0], 2'b00};
          end else begin
            rem_q <= {div_rem[28:0], 1'b0};
            q_q   <= {q_q[25:0], div_ge};
          end
          if (cnt_q == LAST_CNT) state_q <= ST_ROUND;
        end
        ST_ROUND: begin
          result_q <= rnd_res;
          flags_q  <= {2'b00, rnd_of, rnd_uf, rnd_nx};
          state_q  <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fp_unit_o.fp_exe_o = '{result: result_q, flags: flags_q, ready: (state_q == ST_DONE)};

  logic unused_bits;
  assign unused_bits = ^{in.data3, in.fmt, in.op, a_q[31], b_q[31]};

endmodule

// File: tb/tb_fp_unit.sv
// Directed bench for fp_unit: vector table plus handshake/reset sequences.
import fp_wire::*;

module tb_fp_unit;

  logic            clock;
  logic            reset;
  fp_unit_in_type  in_s;
  fp_unit_out_type out_s;

  fp_unit dut (
    .clock     (clock),
    .reset     (reset),
    .fp_unit_i (in_s),
    .fp_unit_o (out_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sq;
    logic [2:0]  rm;
    logic [31:0] res;
    logic [4:0]  flg;
    int          lat;
  } vec_t;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic sq,
                       input logic [2:0] rm, input logic none);
    in_s.fp_exe_i.data1  = a;
    in_s.fp_exe_i.data2  = b;
    in_s.fp_exe_i.data3  = 32'hDEADBEEF;
    in_s.fp_exe_i.fmt    = 2'd0;
    in_s.fp_exe_i.rm     = rm;
    in_s.fp_exe_i.op     = init_fp_operation;
    if (!none) begin
      if (sq) in_s.fp_exe_i.op.fsqrt = 1'b1;
      else    in_s.fp_exe_i.op.fdiv  = 1'b1;
    end
    in_s.fp_exe_i.enable = 1'b1;
  endtask

  // lat counts cycles until ready: 1 = the cycle right after the start edge.
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic sq,
                     input logic [2:0] rm, input logic none, input bit poke,
                     output logic [31:0] r, output logic [4:0] f, output int lat);
    @(posedge clock);
    @(negedge clock);
    drive(a, b, sq, rm, none);
    @(posedge clock); #1;
    in_s.fp_exe_i.enable = 1'b0;
    lat = 1;
    while (!out_s.fp_exe_o.ready && lat < 60) begin
      if (poke && lat == 5) begin
        @(negedge clock);
        drive(32'h40800000, 32'h0, 1'b1, 3'd0, 1'b0);
      end
      @(posedge clock); #1;
      in_s.fp_exe_i.enable = 1'b0;
      lat++;
    end
    r = out_s.fp_exe_o.result;
    f = out_s.fp_exe_o.flags;
  endtask

  vec_t        vt[24];
  logic [31:0] r;
  logic [4:0]  f;
  int          lat;
  bit          seen;

  initial begin
    vt[0]  = '{32'h40400000, 32'h40000000, 1'b0, 3'd0, 32'h3FC00000, 5'h00, 30};
    vt[1]  = '{32'h3F800000, 32'h40400000, 1'b0, 3'd0, 32'h3EAAAAAB, 5'h01, 30};
    vt[2]  = '{32'h3F800000, 32'h40400000, 1'b0, 3'd1, 32'h3EAAAAAA, 5'h01, 30};
    vt[3]  = '{32'h3F800000, 32'h40400000, 1'b0, 3'd3, 32'h3EAAAAAB, 5'h01, 30};
    vt[4]  = '{32'h3F800000, 32'h40400000, 1'b0, 3'd2, 32'h3EAAAAAA, 5'h01, 30};
    vt[5]  = '{32'hBF800000, 32'h40400000, 1'b0, 3'd2, 32'hBEAAAAAB, 5'h01, 30};
    vt[6]  = '{32'h3F800000, 32'h40400000, 1'b0, 3'd5, 32'h3EAAAAAB, 5'h01, 30};
    vt[7]  = '{32'h3F800000, 32'h00000000, 1'b0, 3'd0, 32'h7F800000, 5'h08, 1};
    vt[8]  = '{32'h00000000, 32'h00000000, 1'b0, 3'd0, 32'h7FC00000, 5'h10, 1};
    vt[9]  = '{32'h7F800001, 32'h3F800000, 1'b0, 3'd0, 32'h7FC00000, 5'h10, 1};
    vt[10] = '{32'h7FC00000, 32'h3F800000, 1'b0, 3'd0, 32'h7FC00000, 5'h00, 1};
    vt[11] = '{32'h7F800000, 32'h40000000, 1'b0, 3'd0, 32'h7F800000, 5'h00, 1};
    vt[12] = '{32'h40000000, 32'hFF800000, 1'b0, 3'd0, 32'h80000000, 5'h00, 1};
    vt[13] = '{32'h7F7FFFFF, 32'h3F000000, 1'b0, 3'd0, 32'h7F800000, 5'h05, 30};
    vt[14] = '{32'h7F7FFFFF, 32'h3F000000, 1'b0, 3'd1, 32'h7F7FFFFF, 5'h05, 30};
    vt[15] = '{32'h00800000, 32'h40000000, 1'b0, 3'd0, 32'h00400000, 5'h00, 30};
    vt[16] = '{32'h00000001, 32'h40000000, 1'b0, 3'd0, 32'h00000000, 5'h03, 30};
    vt[17] = '{32'h00000001, 32'h40000000, 1'b0, 3'd3, 32'h00000001, 5'h03, 30};
    vt[18] = '{32'h40800000, 32'h00000000, 1'b1, 3'd0, 32'h40000000, 5'h00, 30};
    vt[19] = '{32'h40000000, 32'h00000000, 1'b1, 3'd0, 32'h3FB504F3, 5'h01, 30};
    vt[20] = '{32'hBF800000, 32'h00000000, 1'b1, 3'd0, 32'h7FC00000, 5'h10, 1};
    vt[21] = '{32'h80000000, 32'h00000000, 1'b1, 3'd0, 32'h80000000, 5'h00, 1};
    vt[22] = '{32'h7F800000, 32'h00000000, 1'b1, 3'd0, 32'h7F800000, 5'h00, 1};
    vt[23] = '{32'h00800000, 32'h00000000, 1'b1, 3'd0, 32'h20000000, 5'h00, 30};

    reset = 1'b0;
    in_s  = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_ready",  {31'b0, out_s.fp_exe_o.ready}, 32'h0);
    chk("reset_result", out_s.fp_exe_o.result, 32'h0);
    chk("reset_flags",  {27'b0, out_s.fp_exe_o.flags}, 32'h0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 24; i++) begin
      run(vt[i].a, vt[i].b, vt[i].sq, vt[i].rm, 1'b0, 1'b0, r, f, lat);
      chk($sformatf("v%0d_result", i), r, vt[i].res);
      chk($sformatf("v%0d_flags", i), {27'b0, f}, {27'b0, vt[i].flg});
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].lat));
      @(posedge clock); #1;
      chk($sformatf("v%0d_ready_pulse", i), {31'b0, out_s.fp_exe_o.ready}, 32'h0);
      chk($sformatf("v%0d_result_hold", i), out_s.fp_exe_o.result, vt[i].res);
    end

    // Enable with no supported operation completes at once with zeros.
    run(32'h3F800000, 32'h40000000, 1'b0, 3'd0, 1'b1, 1'b0, r, f, lat);
    chk("noop_result",  r, 32'h0);
    chk("noop_flags",   {27'b0, f}, 32'h0);
    chk("noop_latency", 32'(lat), 32'd1);

    // A second enable mid-division must not disturb it.
    run(32'h3F800000, 32'h40400000, 1'b0, 3'd0, 1'b0, 1'b1, r, f, lat);
    chk("busy_en_result",  r, 32'h3EAAAAAB);
    chk("busy_en_flags",   {27'b0, f}, 32'h01);
    chk("busy_en_latency", 32'(lat), 32'd30);
    @(posedge clock); #1;
    chk("busy_en_no_second_ready", {31'b0, out_s.fp_exe_o.ready}, 32'h0);
    seen = 1'b0;
    repeat (35) begin
      @(posedge clock); #1;
      if (out_s.fp_exe_o.ready) seen = 1'b1;
    end
    chk("busy_en_stays_idle", {31'b0, seen}, 32'h0);

    // Reset mid-division aborts without a ready pulse.
    @(posedge clock);
    @(negedge clock);
    drive(32'h40400000, 32'h40000000, 1'b0, 3'd0, 1'b0);
    @(posedge clock); #1;
    in_s.fp_exe_i.enable = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_mid_ready",  {31'b0, out_s.fp_exe_o.ready}, 32'h0);
    chk("rst_mid_result", out_s.fp_exe_o.result, 32'h0);
    chk("rst_mid_flags",  {27'b0, out_s.fp_exe_o.flags}, 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (out_s.fp_exe_o.ready) seen = 1'b1;
    end
    chk("rst_mid_no_ready", {31'b0, seen}, 32'h0);
    run(32'h40400000, 32'h40000000, 1'b0, 3'd0, 1'b0, 1'b0, r, f, lat);
    chk("after_rst_result",  r, 32'h3FC00000);
    chk("after_rst_flags",   {27'b0, f}, 32'h0);
    chk("after_rst_latency", 32'(lat), 32'd30);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/fp_unit.md
Name: fp_unit

Overview:
- Single-precision (binary32) floating-point execute unit, IEEE 754 / RISC-V F semantics.
- This revision implements division and square root with an iterative datapath.
- Request/response over one packed input struct and one packed output struct, as used by the core's FP pipeline.
- The remaining operation bits are reserved for future units.

Parameters:
- none (format fixed at binary32; fmt input must be 0).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- fp_unit_i  input  fp_unit_in_type  sub-struct fp_exe_i:
  - data1/data2/data3: 32 each.
  - fmt: 2.
  - rm: 3.
  - op: fp_operation_type, bits fmadd, fadd, fsub, fmul, fdiv, fsqrt, fcmp, fcvt_i2f, fcvt_f2i, fcvt_op.
  - enable: 1.
- fp_unit_o  output  fp_unit_out_type  sub-struct fp_exe_o:
  - result: 32.
  - flags: 5.
  - ready: 1.

Behaviour:
- Reset (reset=0, asynchronous): FSM to IDLE; result=0, flags=0, ready=0.
- Start: enable=1 in IDLE with op.fdiv=1 (data1/data2) or op.fsqrt=1 (data1) latches operands and rm.
  - data3 is ignored.
  - enable while BUSY is ignored.
  - enable with neither fdiv nor fsqrt set: ready=1 next cycle, result=0, flags=0.
- FSM:
  - IDLE -> BUSY: on valid start, normal operands.
  - IDLE -> DONE: on start with special operands; ready the following cycle.
  - BUSY: one quotient/root bit per cycle (radix-2 restoring). 26 bits plus guard, then sticky from the nonzero remainder.
  - BUSY -> ROUND -> DONE.
  - DONE: ready=1 for exactly one cycle, then IDLE.
- Latency: start-to-ready is fixed at 30 cycles for normal/subnormal operands and 1 cycle for special cases.
- result and flags are valid while ready=1 and hold until the next completion.
- Subnormal inputs are normalised before iteration (leading-zero count, exponent adjust).
- Subnormal outputs are denormalised before rounding.
- rm encodings:
  - 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM.
  - 5–7 behave as RNE.
- flags[4:0] = NV, DZ, OF, UF, NX.
  - UF = tiny after rounding AND inexact.
  - OF always sets NX.
- Overflow result depends on rm and sign:
  - Infinity for RNE/RMM, RUP with positive sign, and RDN with negative sign.
  - Otherwise the largest finite value 0x7F7FFFFF with the sign applied.
- Div specials (sign = XOR of signs):
  - Any NaN operand gives 0x7FC00000. NV is set only if an operand is a signalling NaN.
  - 0/0 or inf/inf: 0x7FC00000, NV.
  - x/0 with x finite nonzero: signed infinity, DZ.
  - inf/x: signed infinity.
  - x/inf or 0/x: signed zero.
- Sqrt specials:
  - NaN: 0x7FC00000, NV only if signalling.
  - Negative nonzero (incl. -inf): 0x7FC00000, NV.
  - ±0 returns the input.
  - +inf returns +inf.
- The only NaN ever produced is canonical 0x7FC00000; NaN payloads and signs are never propagated.
- Reset mid-operation aborts the operation; no ready pulse is produced.

Decomposition:
- Package fp_wire holds:
  - fp_operation_type and init_fp_operation (all zero).
  - fp_exe_in_type, fp_exe_out_type, fp_unit_in_type, fp_unit_out_type.
  - Rounding-mode and flag-bit constants.
- Sub-module fp_rnd: combinational rounding.
  - Inputs: sign, biased exponent, mantissa with guard/sticky, rm.
  - Outputs: packed result and the OF/UF/NX flags.
- fp_unit holds the FSM and the shared div/sqrt iteration datapath.

Test Plan:
- Div 0x40400000 / 0x40000000, RNE -> 0x3FC00000, flags 0x00. Then 0x3F800000 / 0x40400000:
  - RNE -> 0x3EAAAAAB, flags 0x01.
  - RTZ -> 0x3EAAAAAA, flags 0x01.
  - RUP -> 0x3EAAAAAB, flags 0x01.
- Div specials:
  - 0x3F800000 / 0x00000000 -> 0x7F800000, flags 0x08.
  - 0/0 -> 0x7FC00000, flags 0x10.
  - 0x7F800001 / 0x3F800000 -> 0x7FC00000, flags 0x10.
- Overflow 0x7F7FFFFF / 0x3F000000:
  - RNE -> 0x7F800000, flags 0x05.
  - RTZ -> 0x7F7FFFFF, flags 0x05.
- Subnormal:
  - 0x00800000 / 0x40000000 -> 0x00400000, flags 0x00.
  - 0x00000001 / 0x40000000, RNE -> 0x00000000, flags 0x03.
  - Same operands, RUP -> 0x00000001, flags 0x03.
- Sqrt:
  - 0x40800000 -> 0x40000000, flags 0x00.
  - 0x40000000 RNE -> 0x3FB504F3, flags 0x01.
  - 0xBF800000 -> 0x7FC00000, flags 0x10.
  - 0x80000000 -> 0x80000000, flags 0x00.
- Handshake: back-to-back ops with enable pulses; enable re-asserted while busy is ignored.
  - Assert reset low mid-division -> no ready pulse; ready=0 and result=0 after reset.
  - Next op completes correctly.
